imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the combinational instruction ROM; owns the fetch PC.
- Drives the ROM address, captures returned words into a small prefetch queue, and hands {pc, instr} to decode via valid/ready.
- Handles redirects from the branch unit (flush + new PC) and flags misaligned redirect targets.

---
 rtl/imem_fetch_ctrl.sv | 88 ++++++++
 tb/tb_imem_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the ROM address and
// buffers {pc, instr} pairs in a small circular prefetch queue for decode.
module imem_fetch_ctrl #(
  parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned  DEPTH     = 2,
  parameter logic [31:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          halted;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic pop;
  logic push;
  logic misaligned;

  assign rom_addr   = fetch_pc;
  assign out_valid  = (count != '0);
  assign out_pc     = out_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign out_instr  = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;

  assign pop        = out_valid & out_ready;
  assign push       = !halted && !redirect_valid && ((count < FULL) || pop);
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // Control state; a redirect flushes the queue and overrides push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= wr_ptr;
      count    <= '0;
      halted   <= misaligned;
      if (misaligned) begin
        misalign_err <= 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= rom_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the fetch/redirect rules.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned DEPTH     = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_err;

  imem_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hff60_0293;
      32'h0000_0004: return 32'h0000_0013;
      32'h0000_0008: return 32'h0000_0013;
      32'h0000_000C: return 32'h0052_8333;
      32'h0000_0048: return 32'h01d3_1863;
      32'h0000_005C: return 32'h0000_2403;
      default:       return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  always_comb rom_data = rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = RESET_PC;
    m_halt = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock edge of the architectural rules, applied to the queue model.
  task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
    bit do_pop;
    bit do_push;
    do_pop = (mq.size() > 0) && rdy;
    if (rv) begin
      mq.delete();
      m_pc   = rpc;
      m_halt = (rpc % 4) != 0;
      if (m_halt) m_err = 1'b1;
    end else begin
      do_push = !m_halt && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: m_pc, instr: rom_fn(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    bit v;
    v = mq.size() > 0;
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("out_pc", out_pc, v ? mq[0].pc : 32'h0);
    chk("out_instr", out_instr, v ? mq[0].instr : NOP_INSTR);
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
    chk("rom_addr", rom_addr, m_pc);
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    check_all();
    model_step(rdy, rv, rpc);
    @(posedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, instr);
  endtask

  // Assert reset between edges, check async clear, then release on a falling edge.
  task automatic do_reset(input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    out_ready      = 1'b0;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, NOP_INSTR);
    chk("rst_misalign_err", 32'(misalign_err), 32'd0);
    chk("rst_rom_addr", rom_addr, RESET_PC);
    model_reset();
    @(negedge clk);
    rst            = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    check_all();
    model_step(out_ready, redirect_valid, redirect_pc);
    @(posedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();

    // Streaming from reset with decode always ready.
    do_reset(1'b0, 32'h0);
    chk_head("first", 32'h0000_0000, 32'hff60_0293);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    // Back-pressure after the first valid entry, then drain.
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    #1 chk("stall_rom_addr", rom_addr, 32'h0000_0008);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);

    // Fill the queue, then redirect to an aligned target.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0048);
    cycle(1'b1, 1'b0, 32'h0);
    chk_head("redir48", 32'h0000_0048, 32'h01d3_1863);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect halts fetch until an aligned redirect.
    cycle(1'b1, 1'b1, 32'h0000_004A);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_005C);
    cycle(1'b1, 1'b0, 32'h0);
    chk_head("redir5c", 32'h0000_005C, 32'h0000_2403);
    chk("sticky_err", 32'(misalign_err), 32'd1);

    // Back-to-back redirects, then PC wrap at the top of the address space.
    cycle(1'b1, 1'b1, 32'h0000_0100);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);
    chk_head("wrap_hi", 32'hFFFF_FFFC, rom_fn(32'hFFFF_FFFC));
    cycle(1'b1, 1'b0, 32'h0);
    chk_head("wrap_lo", 32'h0000_0000, 32'hff60_0293);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    // Reset while full and mid-redirect.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    do_reset(1'b1, 32'h0000_0200);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      int          sel;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      rpc = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
      else if (sel == 1) rpc = 32'hFFFF_FFF8;
      else               rpc = 32'({$urandom_range(0, 63), 2'b00});
      cycle(rdy, rv, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
